// File: rtl/mem_host_pkg.sv
// Shared types and width helpers for the host-side scratchpad loader.
// Imported by mem_host_loader.
package mem_host_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LEN_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WACK,
        RD_ADDR,
        RD_RESP
    } state_e;

    // Bytes per memory word.
    function automatic int mask_width(input int data_width);
        return data_width / 8;
    endfunction

    // Number of byte-offset address bits inside one word.
    function automatic int ofs_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_host_loader.sv
// Host initiator for the scratchpad host ports: turns burst commands into
// byte-masked word writes (hw_*) and combinational word reads (hr_*).
module mem_host_loader
    import mem_host_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_W      = DEFAULT_LEN_W
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [LEN_W-1:0]          req_len,

    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wmask,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_last,

    output logic                      wr_done,
    output logic                      busy,

    output logic [31:0]               hw_addr,
    output logic [DATA_WIDTH-1:0]     hw_data,
    output logic [DATA_WIDTH/8-1:0]   hw_mask,
    output logic                      hw_en,

    output logic [31:0]               hr_addr,
    input  logic [DATA_WIDTH-1:0]     hr_data
);

    localparam int          MASK_WIDTH = mask_width(DATA_WIDTH);
    localparam int          OFS        = ofs_width(DATA_WIDTH);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFS) - 32'd1);
    localparam logic [31:0] ADDR_STEP  = 32'(MASK_WIDTH);

    state_e                  state_q,      state_d;
    logic [31:0]             cur_addr_q,   cur_addr_d;
    logic [LEN_W-1:0]        beats_left_q, beats_left_d;

    logic [31:0]             hw_addr_q,    hw_addr_d;
    logic [DATA_WIDTH-1:0]   hw_data_q,    hw_data_d;
    logic [MASK_WIDTH-1:0]   hw_mask_q,    hw_mask_d;
    logic                    hw_en_q,      hw_en_d;

    logic                    rsp_valid_q,  rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,   rsp_data_d;
    logic                    rsp_last_q,   rsp_last_d;

    logic                    last_beat;

    assign last_beat = (beats_left_q == '0);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        hw_addr_d    = hw_addr_q;
        hw_data_d    = hw_data_q;
        hw_mask_d    = hw_mask_q;
        hw_en_d      = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_last_d   = rsp_last_q;
        req_ready    = 1'b0;
        wdata_ready  = 1'b0;
        wr_done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_addr_d   = req_addr & ALIGN_MASK;
                    beats_left_d = req_len;
                    state_d      = req_write ? WRITE : RD_ADDR;
                end
            end

            WRITE: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    hw_addr_d    = cur_addr_q;
                    hw_data_d    = wdata;
                    hw_mask_d    = wmask;
                    hw_en_d      = 1'b1;
                    cur_addr_d   = cur_addr_q + ADDR_STEP;
                    beats_left_d = beats_left_q - LEN_W'(1);
                    if (last_beat) begin
                        state_d = WACK;
                    end
                end
            end

            // The final hw_en beat is on the bus during this cycle, so the
            // memory has taken it before req_ready can rise again.
            WACK: begin
                wr_done = 1'b1;
                state_d = IDLE;
            end

            RD_ADDR: begin
                rsp_data_d  = hr_data;
                rsp_valid_d = 1'b1;
                rsp_last_d  = last_beat;
                state_d     = RD_RESP;
            end

            RD_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        cur_addr_d   = cur_addr_q + ADDR_STEP;
                        beats_left_d = beats_left_q - LEN_W'(1);
                        state_d      = RD_ADDR;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            hw_addr_q    <= '0;
            hw_data_q    <= '0;
            hw_mask_q    <= '0;
            hw_en_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            hw_addr_q    <= hw_addr_d;
            hw_data_q    <= hw_data_d;
            hw_mask_q    <= hw_mask_d;
            hw_en_q      <= hw_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign hr_addr   = cur_addr_q;

    assign hw_addr   = hw_addr_q;
    assign hw_data   = hw_data_q;
    assign hw_mask   = hw_mask_q;
    assign hw_en     = hw_en_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_mem_host_loader.sv
// Self-checking bench for mem_host_loader: a small word memory on the hw_/hr_
// ports plus a byte-level reference image used to predict every read.
module tb_mem_host_loader;

    localparam int DW = 32;
    localparam int LW = 4;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            req_valid, req_ready, req_write;
    logic [31:0]     req_addr;
    logic [LW-1:0]   req_len;
    logic            wdata_valid, wdata_ready;
    logic [DW-1:0]   wdata;
    logic [MW-1:0]   wmask;
    logic            rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0]   rsp_data;
    logic            wr_done, busy;
    logic [31:0]     hw_addr, hr_addr;
    logic [DW-1:0]   hw_data, hr_data;
    logic [MW-1:0]   hw_mask;
    logic            hw_en;

    mem_host_loader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .wmask(wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .wr_done(wr_done), .busy(busy),
        .hw_addr(hw_addr), .hw_data(hw_data), .hw_mask(hw_mask), .hw_en(hw_en),
        .hr_addr(hr_addr), .hr_data(hr_data)
    );

    // 256-word memory; addresses alias on bits [9:2], identically in the model.
    logic [31:0] tb_mem [256];
    logic        mem_clear;
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return {i, 8'hC3, ~i, 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(8'(i));
        end else begin
            if (hw_en)
                for (int b = 0; b < MW; b++)
                    if (hw_mask[b]) tb_mem[hw_addr[9:2]][8*b +: 8] <= hw_data[8*b +: 8];
            if (poke_en) tb_mem[poke_idx] <= poke_val;
        end
    end

    assign hr_data = tb_mem[hr_addr[9:2]];

    // Reference model
    logic [31:0] ref_mem [256];
    logic [31:0] wbuf_data [16];
    logic [3:0]  wbuf_mask [16];
    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] widx(input logic [31:0] a);
        return a[9:2];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [3:0] len);
        int n;
        n = 0;
        req_write = wr;
        req_addr  = a;
        req_len   = len;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept: req_ready=%0b after %0d cycles, want 1", req_ready, n);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] a, input int len, input int gap_max);
        logic [31:0] exp_addr;
        int gap;
        exp_addr = a & 32'hFFFF_FFFC;
        send_cmd(1'b1, a, 4'(len));
        for (int i = 0; i <= len; i++) begin
            gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            for (int g = 0; g < gap; g++) begin
                wdata_valid = 1'b0;
                wdata = $urandom;
                tick();
                total++;
                if (hw_en !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_gap: hw_en=%0b busy=%0b, want 0/1", hw_en, busy);
                end
            end
            wdata_valid = 1'b1;
            wdata       = wbuf_data[i];
            wmask       = wbuf_mask[i];
            total++;
            if (wdata_ready !== 1'b1) begin
                bad++;
                $display("FAIL wr_ready: beat %0d wdata_ready=%0b, want 1", i, wdata_ready);
            end
            tick();
            total++;
            if (hw_en !== 1'b1 || hw_addr !== exp_addr || hw_data !== wbuf_data[i] ||
                hw_mask !== wbuf_mask[i]) begin
                bad++;
                $display("FAIL wr_beat: beat %0d en=%0b addr=%h data=%h mask=%h, want 1 %h %h %h",
                         i, hw_en, hw_addr, hw_data, hw_mask, exp_addr, wbuf_data[i], wbuf_mask[i]);
            end
            total++;
            if (wr_done !== (i == len)) begin
                bad++;
                $display("FAIL wr_done_timing: beat %0d wr_done=%0b, want %0b", i, wr_done, i == len);
            end
            ref_mem[widx(exp_addr)] = merge(ref_mem[widx(exp_addr)], wbuf_data[i], wbuf_mask[i]);
            exp_addr = exp_addr + 32'd4;
        end
        wdata_valid = 1'b0;
        tick();
        total++;
        if (wr_done !== 1'b0 || hw_en !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_end: wr_done=%0b hw_en=%0b req_ready=%0b busy=%0b, want 0 0 1 0",
                     wr_done, hw_en, req_ready, busy);
        end
    endtask

    task automatic run_read(input logic [31:0] a, input int len, input int stall_min,
                            input int stall_max, input bit poke);
        logic [31:0] exp_addr, exp;
        int stall;
        exp_addr = a & 32'hFFFF_FFFC;
        send_cmd(1'b0, a, 4'(len));
        for (int i = 0; i <= len; i++) begin
            total++;
            if (rsp_valid !== 1'b0 || hr_addr !== exp_addr) begin
                bad++;
                $display("FAIL rd_addr: beat %0d rsp_valid=%0b hr_addr=%h, want 0 %h",
                         i, rsp_valid, hr_addr, exp_addr);
            end
            stall = int'($urandom_range(stall_max, stall_min));
            rsp_ready = (stall == 0);
            tick();
            exp = ref_mem[widx(exp_addr)];
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_last !== (i == len)) begin
                bad++;
                $display("FAIL rd_beat: beat %0d valid=%0b data=%h last=%0b, want 1 %h %0b",
                         i, rsp_valid, rsp_data, rsp_last, exp, i == len);
            end
            for (int s = 0; s < stall; s++) begin
                if (poke && s == 0) begin
                    poke_en  = 1'b1;
                    poke_idx = widx(exp_addr);
                    poke_val = ~exp;
                end
                tick();
                poke_en = 1'b0;
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_last !== (i == len)) begin
                    bad++;
                    $display("FAIL rd_stall: beat %0d valid=%0b data=%h last=%0b, want 1 %h %0b",
                             i, rsp_valid, rsp_data, rsp_last, exp, i == len);
                end
            end
            if (poke && stall > 0) ref_mem[widx(exp_addr)] = ~exp;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            exp_addr = exp_addr + 32'd4;
        end
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_end: rsp_valid=%0b req_ready=%0b busy=%0b, want 0 1 0",
                     rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_clear = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        tick();
        tick();
        mem_clear = 1'b0;
        reset = 1'b0;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || wdata_ready !== 1'b0 || wr_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: req_ready=%0b busy=%0b wdata_ready=%0b wr_done=%0b, want 1 0 0 0",
                     req_ready, busy, wdata_ready, wr_done);
        end
        total++;
        if (hw_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || hr_addr !== 32'h0 ||
            hw_addr !== 32'h0 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: hw_en=%0b rsp_valid=%0b rsp_last=%0b hr_addr=%h hw_addr=%h rsp_data=%h, want all 0",
                     hw_en, rsp_valid, rsp_last, hr_addr, hw_addr, rsp_data);
        end
    endtask

    task automatic test_single_write();
        wbuf_data[0] = 32'hDEAD_BEEF;
        wbuf_mask[0] = 4'hF;
        run_write(32'h100, 0, 0);
        run_read(32'h100, 0, 0, 0, 1'b0);
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 4; i++) begin
            wbuf_data[i] = $urandom;
            wbuf_mask[i] = 4'hF;
        end
        run_write(32'h203, 3, 0);
    endtask

    task automatic test_byte_mask();
        wbuf_data[0] = 32'h1122_3344;
        wbuf_mask[0] = 4'hF;
        run_write(32'h10, 0, 0);
        wbuf_data[0] = 32'h0000_AB00;
        wbuf_mask[0] = 4'h2;
        run_write(32'h10, 0, 0);
        total++;
        if (tb_mem[4] !== 32'h1122_AB44) begin
            bad++;
            $display("FAIL byte_mask: mem[0x10]=%h, want 1122ab44", tb_mem[4]);
        end
        wbuf_data[0] = $urandom;
        wbuf_mask[0] = 4'h0;
        run_write(32'h10, 0, 0);
        total++;
        if (tb_mem[4] !== 32'h1122_AB44) begin
            bad++;
            $display("FAIL zero_mask: mem[0x10]=%h, want 1122ab44", tb_mem[4]);
        end
        run_read(32'h10, 0, 1, 1, 1'b0);
    endtask

    task automatic test_read_stall();
        run_read(32'h200, 3, 3, 3, 1'b1);
    endtask

    task automatic test_wrap();
        wbuf_data[0] = 32'hCAFE_0001;
        wbuf_data[1] = 32'hCAFE_0002;
        wbuf_mask[0] = 4'hF;
        wbuf_mask[1] = 4'hF;
        run_write(32'hFFFF_FFFC, 1, 0);
        run_read(32'hFFFF_FFFC, 1, 0, 1, 1'b0);
    endtask

    task automatic test_wdata_ignored();
        wdata_valid = 1'b1;
        wdata = 32'h5555_AAAA;
        wmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wdata_ready !== 1'b0) begin
                bad++;
                $display("FAIL idle_wready: wdata_ready=%0b, want 0", wdata_ready);
            end
            tick();
            total++;
            if (hw_en !== 1'b0) begin
                bad++;
                $display("FAIL idle_hw_en: hw_en=%0b, want 0", hw_en);
            end
        end
        wdata_valid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        send_cmd(1'b0, 32'h200, 4'd3);
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_rd_pre: rsp_valid=%0b, want 1", rsp_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_rd: cycle %0d rsp_valid=%0b busy=%0b req_ready=%0b, want 0 0 1",
                         i, rsp_valid, busy, req_ready);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = $urandom;
        send_cmd(1'b1, 32'h300, 4'd3);
        for (int i = 0; i < 3; i++) begin
            wdata_valid = 1'b1;
            wdata = d[i];
            wmask = 4'hF;
            if (i == 2) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        wdata_valid = 1'b0;
        ref_mem[widx(32'h300)] = d[0];
        ref_mem[widx(32'h304)] = d[1];
        for (int i = 0; i < 3; i++) begin
            total++;
            if (hw_en !== 1'b0 || wr_done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_wr: cycle %0d hw_en=%0b wr_done=%0b busy=%0b, want 0 0 0",
                         i, hw_en, wr_done, busy);
            end
            tick();
        end
        wbuf_data[0] = $urandom;
        wbuf_mask[0] = 4'h5;
        run_write(32'h30C, 0, 0);
        run_read(32'h300, 3, 0, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int len;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFE0 + 32'($urandom_range(31, 0));
            else a = 32'($urandom_range(1023, 0));
            len = int'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wbuf_data[i] = $urandom;
                    wbuf_mask[i] = 4'($urandom);
                end
                run_write(a, len, 2);
            end else begin
                run_read(a, len, 0, 3, $urandom_range(3, 0) == 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_clear = 1'b0;
        poke_en = 1'b0;
        poke_idx = '0;
        poke_val = '0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_len = '0;
        wdata_valid = 1'b0;
        wdata = '0;
        wmask = '0;
        rsp_ready = 1'b0;

        test_reset();
        test_single_write();
        test_write_burst();
        test_byte_mask();
        test_read_stall();
        test_wrap();
        test_wdata_ignored();
        test_reset_mid_read();
        test_reset_mid_write();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
